// File: rtl/dcache_pkg.sv
// Shared types and width helpers for the write-through data cache.
package dcache_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REFILL = 2'd1,
    WRITE  = 2'd2
  } dcache_state_e;

  function automatic int bo_bits(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int tag_bits(input int aw, input int iw, input int ow, input int dw);
    return aw - iw - ow - bo_bits(dw);
  endfunction

endpackage

// File: rtl/data_cache_array.sv
// Tag and line-data storage: combinational lookup, one synchronous word write
// port and a separate tag write. Neither array is reset.
module data_cache_array
  import dcache_pkg::*;
#(
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 2,
  parameter int TAG_WIDTH    = 26
) (
  input  logic                    clk,
  input  logic [INDEX_WIDTH-1:0]  rd_index_i,
  input  logic [OFFSET_WIDTH-1:0] rd_offset_i,
  output logic [DATA_WIDTH-1:0]   rd_data_o,
  output logic [TAG_WIDTH-1:0]    rd_tag_o,
  input  logic                    wr_en_i,
  input  logic [INDEX_WIDTH-1:0]  wr_index_i,
  input  logic [OFFSET_WIDTH-1:0] wr_offset_i,
  input  logic [DATA_WIDTH-1:0]   wr_data_i,
  input  logic                    tag_we_i,
  input  logic [TAG_WIDTH-1:0]    tag_wdata_i
);

  localparam int SETS       = 1 << INDEX_WIDTH;
  localparam int LINE_WORDS = 1 << OFFSET_WIDTH;

  logic [LINE_WORDS-1:0][DATA_WIDTH-1:0] data_q [SETS];
  logic [TAG_WIDTH-1:0]                  tag_q  [SETS];

  assign rd_data_o = data_q[rd_index_i][rd_offset_i];
  assign rd_tag_o  = tag_q[rd_index_i];

  always_ff @(posedge clk) begin
    if (wr_en_i)  data_q[wr_index_i][wr_offset_i] <= wr_data_i;
    if (tag_we_i) tag_q[wr_index_i] <= tag_wdata_i;
  end

endmodule

// File: rtl/data_cache_wt.sv
// Direct-mapped write-through, no-write-allocate data cache with blocking
// line refill. Define DCACHE_STATS_EN to add hit/miss counters.
module data_cache_wt
  import dcache_pkg::*;
#(
  parameter int ADDR_WIDTH   = 32,
  parameter int DATA_WIDTH   = 32,
  parameter int INDEX_WIDTH  = 4,
  parameter int OFFSET_WIDTH = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cpu_valid,
  input  logic                  cpu_we,
  input  logic [ADDR_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0] cpu_wdata,
  output logic                  cpu_ready,
  output logic [DATA_WIDTH-1:0] cpu_rdata,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic                  mem_ready,
  input  logic [DATA_WIDTH-1:0] mem_rdata
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]           hit_count,
  output logic [31:0]           miss_count
`endif
);

  localparam int BO         = bo_bits(DATA_WIDTH);
  localparam int TW         = tag_bits(ADDR_WIDTH, INDEX_WIDTH, OFFSET_WIDTH, DATA_WIDTH);
  localparam int SETS       = 1 << INDEX_WIDTH;
  localparam int LINE_WORDS = 1 << OFFSET_WIDTH;

  dcache_state_e             state_q, state_d;
  logic [SETS-1:0]           valid_q, valid_d;
  logic [OFFSET_WIDTH-1:0]   cnt_q, cnt_d;
  logic [TW-1:0]             tag_q, tag_d;
  logic [INDEX_WIDTH-1:0]    idx_q, idx_d;

  logic [TW-1:0]             req_tag, rd_tag;
  logic [INDEX_WIDTH-1:0]    req_index, wr_index;
  logic [OFFSET_WIDTH-1:0]   req_off, wr_offset;
  logic [DATA_WIDTH-1:0]     wr_data;
  logic                      wr_en, tag_we, hit;

  assign req_tag   = cpu_addr[ADDR_WIDTH-1 -: TW];
  assign req_index = cpu_addr[BO+OFFSET_WIDTH +: INDEX_WIDTH];
  assign req_off   = cpu_addr[BO +: OFFSET_WIDTH];
  assign hit       = valid_q[req_index] && (rd_tag == req_tag);

  data_cache_array #(
    .DATA_WIDTH  (DATA_WIDTH),
    .INDEX_WIDTH (INDEX_WIDTH),
    .OFFSET_WIDTH(OFFSET_WIDTH),
    .TAG_WIDTH   (TW)
  ) u_array (
    .clk        (clk),
    .rd_index_i (req_index),
    .rd_offset_i(req_off),
    .rd_data_o  (cpu_rdata),
    .rd_tag_o   (rd_tag),
    .wr_en_i    (wr_en),
    .wr_index_i (wr_index),
    .wr_offset_i(wr_offset),
    .wr_data_i  (wr_data),
    .tag_we_i   (tag_we),
    .tag_wdata_i(tag_q)
  );

  always_comb begin
    state_d   = state_q;
    valid_d   = valid_q;
    cnt_d     = cnt_q;
    tag_d     = tag_q;
    idx_d     = idx_q;
    cpu_ready = 1'b0;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = cpu_wdata;
    wr_en     = 1'b0;
    wr_index  = req_index;
    wr_offset = req_off;
    wr_data   = cpu_wdata;
    tag_we    = 1'b0;
    case (state_q)
      IDLE: begin
        if (cpu_valid) begin
          if (cpu_we) begin
            state_d = WRITE;
          end else if (hit) begin
            cpu_ready = 1'b1;
          end else begin
            // Invalidate up front so an aborted refill never leaves a partial line valid.
            valid_d[req_index] = 1'b0;
            tag_d   = req_tag;
            idx_d   = req_index;
            cnt_d   = '0;
            state_d = REFILL;
          end
        end
      end
      REFILL: begin
        mem_req  = 1'b1;
        mem_addr = ADDR_WIDTH'({tag_q, idx_q, cnt_q}) << BO;
        if (mem_ready) begin
          wr_en     = 1'b1;
          wr_index  = idx_q;
          wr_offset = cnt_q;
          wr_data   = mem_rdata;
          cnt_d     = cnt_q + OFFSET_WIDTH'(1);
          if (cnt_q == OFFSET_WIDTH'(LINE_WORDS - 1)) begin
            tag_we         = 1'b1;
            valid_d[idx_q] = 1'b1;
            state_d        = IDLE;
          end
        end
      end
      WRITE: begin
        mem_req  = 1'b1;
        mem_we   = 1'b1;
        mem_addr = (cpu_addr >> BO) << BO;
        if (mem_ready) begin
          cpu_ready = 1'b1;
          wr_en     = hit;
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    if (rst) begin
      cpu_ready = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      wr_en     = 1'b0;
      tag_we    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      valid_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    tag_q <= tag_d;
    idx_q <= idx_d;
  end

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_q, miss_q;
  logic        rd_lookup;

  assign rd_lookup = (state_q == IDLE) && cpu_valid && !cpu_we;

  always_ff @(posedge clk) begin
    if (rst) begin
      hit_q  <= '0;
      miss_q <= '0;
    end else begin
      if (rd_lookup && hit)  hit_q  <= hit_q + 32'd1;
      if (rd_lookup && !hit) miss_q <= miss_q + 32'd1;
    end
  end

  assign hit_count  = hit_q;
  assign miss_count = miss_q;
`endif

endmodule

// File: tb/tb_data_cache_wt.sv
// Directed bench for data_cache_wt: scoreboard queues for load data and memory
// transactions, a wait-state memory model, and latency checks.
module tb_data_cache_wt;

  logic        clk = 1'b0;
  logic        rst, cpu_valid, cpu_we, cpu_ready;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
`ifdef DCACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  always #5 clk = ~clk;

  data_cache_wt dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_valid(cpu_valid),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_wdata(cpu_wdata),
    .cpu_ready(cpu_ready),
    .cpu_rdata(cpu_rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_wdata(mem_wdata),
    .mem_ready(mem_ready),
    .mem_rdata(mem_rdata)
`ifdef DCACHE_STATS_EN
    ,
    .hit_count (hit_count),
    .miss_count(miss_count)
`endif
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          wait_n   = 0;
  int          wcnt     = 0;
  logic [31:0] mem [logic [31:0]];
  logic [31:0] exp_q [$];
  logic [32:0] mexp_q [$];

  // Unwritten memory: 0xA0 + word index, with the line number folded into the upper bytes.
  function automatic logic [31:0] model(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return 32'hA0 + {30'b0, a[3:2]} + (((a >> 4) ^ 32'h10) << 8);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_line(input logic [31:0] base);
    for (int w = 0; w < 4; w++) mexp_q.push_back({1'b0, base + 32'(w * 4)});
  endtask

  task automatic req(input string tag, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input logic [31:0] exp_rd,
                     input int exp_lat, input int abort_after);
    int lat, nrd;
    bit done, aborted;
    if (!we) exp_q.push_back(exp_rd);
    @(negedge clk);
    cpu_valid = 1'b1; cpu_we = we; cpu_addr = addr; cpu_wdata = wdata;
    lat = 0; nrd = 0; done = 0; aborted = 0;
    while (!done) begin
      #1;
      mem_ready = mem_req && (wcnt >= wait_n);
      mem_rdata = model(mem_addr);
      #1;
      if (mem_req && mem_ready) begin
        chk({tag, "/mem"}, 64'({mem_we, mem_addr}),
            mexp_q.size() != 0 ? 64'(mexp_q.pop_front()) : 64'h1_DEAD_0000);
        if (mem_we) chk({tag, "/mem_wdata"}, 64'(mem_wdata), 64'(wdata));
        else nrd++;
      end
      if (cpu_ready) begin
        chk({tag, "/latency"}, 64'(lat), 64'(exp_lat));
        if (!we) chk({tag, "/rdata"}, 64'(cpu_rdata),
                     exp_q.size() != 0 ? 64'(exp_q.pop_front()) : 64'hBAD);
        done = 1;
      end else if (lat > 200) begin
        chk({tag, "/timeout"}, 64'(lat), 64'(exp_lat));
        done = 1;
      end
      if (mem_req && mem_ready) begin
        wcnt = 0;
        if (mem_we) mem[mem_addr] = mem_wdata;
      end else if (mem_req) wcnt++;
      else wcnt = 0;
      if (!done && abort_after >= 0 && nrd == abort_after) begin
        @(negedge clk);
        rst = 1'b1; mem_ready = 1'b0;
        #1;
        chk({tag, "/rst_cpu_ready"}, 64'(cpu_ready), 64'd0);
        chk({tag, "/rst_mem_req"}, 64'(mem_req), 64'd0);
        @(negedge clk);
        rst = 1'b0; cpu_valid = 1'b0; wcnt = 0;
        exp_q.delete(); mexp_q.delete();
        done = 1; aborted = 1;
      end
      if (!done) begin
        @(negedge clk);
        lat++;
      end
    end
    if (!aborted) begin
      @(posedge clk);
      #1;
      cpu_valid = 1'b0; mem_ready = 1'b0; wcnt = 0;
    end
    #1;
    // A transaction must be finished before cpu_valid is released.
    chk({tag, "/idle_after"}, 64'(mem_req), 64'd0);
  endtask

  initial begin
    rst = 1'b1; cpu_valid = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    mem_ready = 1'b0; mem_rdata = '0;
    @(negedge clk); @(negedge clk); #1;
    chk("reset/cpu_ready", 64'(cpu_ready), 64'd0);
    chk("reset/mem_req", 64'(mem_req), 64'd0);
    chk("reset/mem_we", 64'(mem_we), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    mem_ready = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    chk("stray_ready/mem_req", 64'(mem_req), 64'd0);
    mem_ready = 1'b0;

    push_line(32'h100);
    req("miss_0x100", 1'b0, 32'h100, '0, 32'hA0, 5, -1);
    req("hit_0x104", 1'b0, 32'h104, '0, 32'hA1, 0, -1);

    push_line(32'h200);
    req("conflict_0x200", 1'b0, 32'h200, '0, 32'h30A1 - 32'h1, 5, -1);
    push_line(32'h100);
    req("reload_0x100", 1'b0, 32'h100, '0, 32'hA0, 5, -1);

    mexp_q.push_back({1'b1, 32'h108});
    req("store_hit_0x108", 1'b1, 32'h108, 32'hDEAD_BEEF, '0, 1, -1);
    req("read_0x108", 1'b0, 32'h108, '0, 32'hDEAD_BEEF, 0, -1);

    mexp_q.push_back({1'b1, 32'h400});
    req("store_miss_0x400", 1'b1, 32'h400, 32'h1234_5678, '0, 1, -1);
    req("no_alloc_0x100", 1'b0, 32'h100, '0, 32'hA0, 0, -1);
    push_line(32'h400);
    req("read_0x400", 1'b0, 32'h400, '0, 32'h1234_5678, 5, -1);

    wait_n = 3;
    push_line(32'h300);
    req("slow_0x300", 1'b0, 32'h300, '0, 32'h20A0, 17, -1);
    wait_n = 0;

    push_line(32'h500);
    req("abort_0x500", 1'b0, 32'h500, '0, 32'h40A0, 5, 2);
    push_line(32'h500);
    req("after_abort_0x500", 1'b0, 32'h500, '0, 32'h40A0, 5, -1);
    push_line(32'h110);
    req("miss_set1_0x110", 1'b0, 32'h110, '0, 32'h1A0, 5, -1);
    req("hit_set0_0x504", 1'b0, 32'h504, '0, 32'h40A1, 0, -1);

`ifdef DCACHE_STATS_EN
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("stats/hit_rst", 64'(hit_count), 64'd0);
    chk("stats/miss_rst", 64'(miss_count), 64'd0);
    rst = 1'b0;
    push_line(32'h100);
    req("stats_miss_0x100", 1'b0, 32'h100, '0, 32'hA0, 5, -1);
    req("stats_hit_0x104", 1'b0, 32'h104, '0, 32'hA1, 0, -1);
    req("stats_hit_0x108", 1'b0, 32'h108, '0, 32'hDEAD_BEEF, 0, -1);
    push_line(32'h200);
    req("stats_miss_0x200", 1'b0, 32'h200, '0, 32'h30A0, 5, -1);
    chk("stats/hit_count", 64'(hit_count), 64'd4);
    chk("stats/miss_count", 64'(miss_count), 64'd2);
`endif

    chk("mem_queue_empty", 64'(mexp_q.size()), 64'd0);
    chk("rd_queue_empty", 64'(exp_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
